train_detector: RTL and testbench

Track-side occupancy detector that generates the `train` request consumed by the crossing light controller. It debounces two raw track sensors: an approach sensor before the crossing and an exit sensor after it. It counts trains currently between the sensors and asserts `train` while the section is occupied. It latches a fail-safe fault on any inconsistent sensor sequence or a stuck train; in that state `train` is held high so the light stays red.

---
 rtl/train_detector.sv | 141 ++++++++++++++
 tb/tb_train_detector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/train_detector.sv
// Track-side occupancy detector: debounces approach/exit sensors, counts trains
// in the section and latches a fail-safe fault that holds `train` high.
module train_detector #(
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned MAX_TRAINS = 3,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enter_s,
    input  logic                              exit_s,
    output logic                              train,
    output logic [$clog2(MAX_TRAINS+1)-1:0]   count,
    output logic                              fault
);

    localparam int unsigned CW = $clog2(MAX_TRAINS + 1);
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OCC   = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          train_q, train_d;
    logic          fault_q, fault_d;

    // Index 0 is the approach sensor, index 1 the exit sensor.
    logic [1:0]    raw;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    deb_prev_q, deb_prev_d;
    logic [1:0]    ev_q, ev_d;
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];

    logic          ent, ext;

    assign raw = {exit_s, enter_s};
    assign ent = ev_q[0];
    assign ext = ev_q[1];

    // Debounce, rising-edge event generation and occupancy FSM.
    always_comb begin
        deb_d      = deb_q;
        dcnt_d     = dcnt_q;
        deb_prev_d = deb_q;
        ev_d       = deb_q & ~deb_prev_q;
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = '0;

        for (int i = 0; i < 2; i++) begin
            if (raw[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE - 1)) begin
                    deb_d[i]  = raw[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end else begin
                dcnt_d[i] = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (ent && !ext) begin
                    state_d = OCC;
                    count_d = CW'(1);
                end else if (ext && !ent) begin
                    state_d = FAULT;
                end
            end
            OCC: begin
                if (ent && ext) begin
                    timer_d = '0;
                end else if (ent) begin
                    if (count_q == CW'(MAX_TRAINS)) begin
                        state_d = FAULT;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (ext) begin
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        train_d = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            timer_q    <= '0;
            train_q    <= 1'b0;
            fault_q    <= 1'b0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            ev_q       <= '0;
            dcnt_q[0]  <= '0;
            dcnt_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            train_q    <= train_d;
            fault_q    <= fault_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            ev_q       <= ev_d;
            dcnt_q[0]  <= dcnt_d[0];
            dcnt_q[1]  <= dcnt_d[1];
        end
    end

    assign train = train_q;
    assign count = count_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_train_detector.sv
// Bench for train_detector: directed segment table, hand-written latency and
// glitch sequences, and random sensor traffic checked against a reference model.
module tb_train_detector;

    localparam int unsigned DB   = 4;
    localparam int unsigned MAXT = 3;
    localparam int unsigned TMO  = 20;
    localparam int unsigned CW   = $clog2(MAXT + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          enter_s;
    logic          exit_s;
    logic          train;
    logic [CW-1:0] count;
    logic          fault;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    train_detector #(
        .DEBOUNCE   (DB),
        .MAX_TRAINS (MAXT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enter_s (enter_s),
        .exit_s  (exit_s),
        .train   (train),
        .count   (count),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    // Reference model: a sensor settles once its last DB raw samples all
    // disagree with the settled value; a settled rise is acted on two edges later.
    bit win  [2][DB];
    int seen [2];
    bit m_deb[2];
    bit dl   [2][2];
    int m_count;
    bit m_fault;
    int m_quiet;

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < int'(DB); k++) win[i][k] = 1'b0;
            seen[i]  = 0;
            m_deb[i] = 1'b0;
            dl[i][0] = 1'b0;
            dl[i][1] = 1'b0;
        end
        m_count = 0;
        m_fault = 1'b0;
        m_quiet = 0;
    endtask

    task automatic model_edge(input bit r, input bit e, input bit x);
        bit raw_i [2];
        bit ev    [2];
        bit rose  [2];
        bit all_diff;
        if (r) begin
            m_reset();
            return;
        end
        raw_i[0] = e;
        raw_i[1] = x;
        for (int i = 0; i < 2; i++) begin
            for (int k = int'(DB) - 1; k > 0; k--) win[i][k] = win[i][k-1];
            win[i][0] = raw_i[i];
            if (seen[i] < int'(DB)) seen[i]++;
            rose[i] = 1'b0;
            if (seen[i] == int'(DB)) begin
                all_diff = 1'b1;
                for (int k = 0; k < int'(DB); k++)
                    if (win[i][k] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) begin
                    rose[i]  = raw_i[i];
                    m_deb[i] = raw_i[i];
                end
            end
            ev[i]    = dl[i][1];
            dl[i][1] = dl[i][0];
            dl[i][0] = rose[i];
        end
        if (!m_fault) begin
            if (ev[0] && ev[1]) begin
                if (m_count > 0) m_quiet = 0;
            end else if (ev[0]) begin
                if (m_count == int'(MAXT)) m_fault = 1'b1;
                else begin
                    m_count++;
                    m_quiet = 0;
                end
            end else if (ev[1]) begin
                if (m_count == 0) m_fault = 1'b1;
                else begin
                    m_count--;
                    m_quiet = 0;
                end
            end else if (m_count > 0) begin
                m_quiet++;
                if (m_quiet >= int'(TMO)) m_fault = 1'b1;
            end
        end
    endtask

    task automatic cmp(input string nm, input bit t, input int c, input bit f);
        vectors++;
        if (train !== t || count !== CW'(c) || fault !== f) begin
            miscompares++;
            $display("FAIL %s: got train=%0b count=%0d fault=%0b, expected train=%0b count=%0d fault=%0b",
                     nm, train, count, fault, t, c, f);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit x);
        rst     = r;
        enter_s = e;
        exit_s  = x;
        @(posedge clk);
        cyc++;
        model_edge(r, e, x);
        #1;
        cmp($sformatf("model@%0d", cyc), m_fault || (m_count > 0), m_count, m_fault);
    endtask

    typedef struct {
        bit r;
        bit e;
        bit x;
        int len;
        bit t;
        int c;
        bit f;
    } seg_t;

    seg_t tbl[$];

    task automatic add(input bit r, input bit e, input bit x, input int len,
                       input bit t, input int c, input bit f);
        seg_t s;
        s.r = r; s.e = e; s.x = x; s.len = len;
        s.t = t; s.c = c; s.f = f;
        tbl.push_back(s);
    endtask

    initial begin
        rst     = 1'b1;
        enter_s = 1'b0;
        exit_s  = 1'b0;
        m_reset();

        // single train in and out
        add(1,0,0,1,  0,0,0);
        add(0,1,0,10, 1,1,0);
        add(0,0,0,6,  1,1,0);
        add(0,0,1,10, 0,0,0);
        add(0,0,0,6,  0,0,0);
        // glitch shorter than DB
        add(0,1,0,3,  0,0,0);
        add(0,0,0,6,  0,0,0);
        // three entries, fourth overflows, exit ignored
        for (int n = 1; n <= 3; n++) begin
            add(0,1,0,6, 1,n,0);
            add(0,0,0,6, 1,n,0);
        end
        add(0,1,0,6,  1,3,1);
        add(0,0,0,6,  1,3,1);
        add(0,0,1,6,  1,3,1);
        add(0,0,0,6,  1,3,1);
        // underflow
        add(1,0,0,1,  0,0,0);
        add(0,0,1,6,  1,0,1);
        add(0,0,0,4,  1,0,1);
        // simultaneous in IDLE, then timeout exactly TMO edges after the event
        add(1,0,0,1,  0,0,0);
        add(0,1,1,6,  0,0,0);
        add(0,0,0,6,  0,0,0);
        add(0,1,0,6,  1,1,0);
        add(0,0,0,19, 1,1,0);
        add(0,0,0,1,  1,1,1);
        // fault with count 2, then reset while enter_s stays high
        add(1,0,0,1,  0,0,0);
        add(0,1,0,6,  1,1,0);
        add(0,0,0,6,  1,1,0);
        add(0,1,0,6,  1,2,0);
        add(0,0,0,20, 1,2,1);
        add(1,1,0,1,  0,0,0);
        add(0,1,0,5,  0,0,0);
        add(0,1,0,1,  1,1,0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].len; k++) step(tbl[i].r, tbl[i].e, tbl[i].x);
            cmp($sformatf("seg%0d", i), tbl[i].t, tbl[i].c, tbl[i].f);
        end

        // Exit glitch of DB-1 cycles ignored, then exact exit latency.
        for (int k = 0; k < int'(DB) - 1; k++) step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        cmp("exit_glitch", 1'b1, 1, 1'b0);
        for (int k = 0; k < int'(DB) + 1; k++) step(0, 1, 1);
        cmp("exit_lat_before", 1'b1, 1, 1'b0);
        step(0, 1, 1);
        cmp("exit_lat_at", 1'b0, 0, 1'b0);

        // Randomized sensor traffic with occasional resets.
        step(1, 0, 0);
        for (int s = 0; s < 400; s++) begin
            int len;
            bit e, x, r;
            len = (($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 26))
                                                : int'($urandom_range(1, 12)));
            e = ($urandom_range(0, 1) == 0);
            x = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 39) == 0) || (m_fault && $urandom_range(0, 2) == 0);
            if (r) step(1, e, x);
            else for (int k = 0; k < len; k++) step(0, e, x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
